// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with per-register pending (scoreboard) bits.
// Optional REG_FILE_BYPASS_EN forwards same-cycle writes onto the read ports.

module reg_file_mp_rd #(
  parameter int WORD_SIZE = 32,
  parameter int REG_INDEX = 5
) (
  input  logic [REG_INDEX-1:0]                         i_idx,
  input  logic [2**REG_INDEX-1:0][WORD_SIZE-1:0]       i_regs,
  input  logic [2**REG_INDEX-1:0]                      i_pend,
  output logic [WORD_SIZE-1:0]                         o_data,
  output logic                                         o_busy
);
  assign o_data = i_regs[i_idx];
  assign o_busy = i_pend[i_idx];
endmodule

module reg_file_mp #(
  parameter int WORD_SIZE  = 32,
  parameter int REG_INDEX  = 5,
  parameter int READ_PORTS = 3
) (
  input  logic                              clk,
  input  logic                              reset_enable,
  input  logic [READ_PORTS*REG_INDEX-1:0]   get_num,
  output logic [READ_PORTS*WORD_SIZE-1:0]   out,
  output logic [READ_PORTS-1:0]             busy,
  input  logic [REG_INDEX-1:0]              set_num0,
  input  logic [WORD_SIZE-1:0]              set_val0,
  input  logic                              set_enable0,
  input  logic [REG_INDEX-1:0]              set_num1,
  input  logic [WORD_SIZE-1:0]              set_val1,
  input  logic                              set_enable1,
  input  logic [REG_INDEX-1:0]              busy_num,
  input  logic                              busy_enable,
  output logic [REG_INDEX:0]                pending_count
);
  localparam int DEPTH = 2**REG_INDEX;

  logic [DEPTH-1:0][WORD_SIZE-1:0]        r_regs, w_regs_nxt;
  logic [DEPTH-1:0]                       r_pend, w_pend_nxt;
  logic [REG_INDEX:0]                     r_pcount, w_pcount_nxt;
  logic                                   w_wr0, w_wr1, w_mark;
  logic [READ_PORTS-1:0][WORD_SIZE-1:0]   w_rd_data, w_out;
  logic [READ_PORTS-1:0]                  w_rd_busy;

  // Index 0 is hardwired: writes and marks to it are dropped here.
  assign w_wr0  = set_enable0 && (set_num0 != '0);
  assign w_wr1  = set_enable1 && (set_num1 != '0);
  assign w_mark = busy_enable && (busy_num != '0);

  always_comb begin
    w_regs_nxt = r_regs;
    if (w_wr0) w_regs_nxt[set_num0] = set_val0;
    if (w_wr1) w_regs_nxt[set_num1] = set_val1;
  end

  // Writes retire the producer; a new mark on the same edge re-arms it.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr0)  w_pend_nxt[set_num0] = 1'b0;
    if (w_wr1)  w_pend_nxt[set_num1] = 1'b0;
    if (w_mark) w_pend_nxt[busy_num] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_pcount_nxt = '0;
    for (int i = 1; i < DEPTH; i++)
      w_pcount_nxt = w_pcount_nxt + (REG_INDEX+1)'(w_pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset_enable) begin
    if (!reset_enable) begin
      r_regs   <= '0;
      r_pend   <= '0;
      r_pcount <= '0;
    end else begin
      r_regs   <= w_regs_nxt;
      r_pend   <= w_pend_nxt;
      r_pcount <= w_pcount_nxt;
    end
  end

  assign pending_count = r_pcount;

  genvar k;
  generate
    for (k = 0; k < READ_PORTS; k++) begin : g_rd
      logic [REG_INDEX-1:0] w_idx;
      assign w_idx = get_num[k*REG_INDEX +: REG_INDEX];

      reg_file_mp_rd #(.WORD_SIZE(WORD_SIZE), .REG_INDEX(REG_INDEX)) u_rd (
        .i_idx  (w_idx),
        .i_regs (r_regs),
        .i_pend (r_pend),
        .o_data (w_rd_data[k]),
        .o_busy (w_rd_busy[k])
      );

`ifdef REG_FILE_BYPASS_EN
      logic w_hit0, w_hit1;
      assign w_hit0   = w_wr0 && (set_num0 == w_idx);
      assign w_hit1   = w_wr1 && (set_num1 == w_idx);
      assign w_out[k] = w_hit1 ? set_val1 : (w_hit0 ? set_val0 : w_rd_data[k]);
      assign busy[k]  = (w_hit0 || w_hit1) ? (w_mark && (busy_num == w_idx)) : w_rd_busy[k];
`else
      assign w_out[k] = w_rd_data[k];
      assign busy[k]  = w_rd_busy[k];
`endif
    end
  endgenerate

  assign out = w_out;
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against an array-based model.
module tb_reg_file_mp;
  localparam int W  = 32;
  localparam int RI = 5;
  localparam int RP = 3;
  localparam int D  = 2**RI;

  logic              clk = 1'b0;
  logic              reset_enable;
  logic [RP*RI-1:0]  get_num;
  logic [RP*W-1:0]   out;
  logic [RP-1:0]     busy;
  logic [RI-1:0]     set_num0, set_num1, busy_num;
  logic [W-1:0]      set_val0, set_val1;
  logic              set_enable0, set_enable1, busy_enable;
  logic [RI:0]       pending_count;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [W-1:0] m_reg [D];
  bit           m_pend[D];

  reg_file_mp #(.WORD_SIZE(W), .REG_INDEX(RI), .READ_PORTS(RP)) dut (
    .clk(clk), .reset_enable(reset_enable), .get_num(get_num), .out(out), .busy(busy),
    .set_num0(set_num0), .set_val0(set_val0), .set_enable0(set_enable0),
    .set_num1(set_num1), .set_val1(set_val1), .set_enable1(set_enable1),
    .busy_num(busy_num), .busy_enable(busy_enable), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin m_reg[i] = '0; m_pend[i] = 0; end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [W-1:0] exp_out(int idx);
    if (idx == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (set_enable1 && int'(set_num1) == idx) return set_val1;
    if (set_enable0 && int'(set_num0) == idx) return set_val0;
`endif
    return m_reg[idx];
  endfunction

  function automatic logic exp_busy(int idx);
    if (idx == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if ((set_enable1 && int'(set_num1) == idx) || (set_enable0 && int'(set_num0) == idx))
      return busy_enable && int'(busy_num) == idx;
`endif
    return m_pend[idx];
  endfunction

  function automatic logic [W-1:0] dout(int k);
    return out[k*W +: W];
  endfunction

  function automatic int port_idx(int k);
    return int'(get_num[k*RI +: RI]);
  endfunction

  task automatic set_port(int k, int idx);
    get_num[k*RI +: RI] = RI'(idx);
  endtask

  task automatic idle();
    set_enable0 = 0; set_enable1 = 0; busy_enable = 0;
    set_num0 = '0; set_num1 = '0; busy_num = '0; set_val0 = '0; set_val1 = '0;
  endtask

  // Advance one edge and apply the spec's update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset_enable) model_clear();
    else begin
      if (set_enable0 && set_num0 != 0) m_reg[set_num0] = set_val0;
      if (set_enable1 && set_num1 != 0) m_reg[set_num1] = set_val1;
      if (set_enable0 && set_num0 != 0) m_pend[set_num0] = 0;
      if (set_enable1 && set_num1 != 0) m_pend[set_num1] = 0;
      if (busy_enable && busy_num != 0) m_pend[busy_num] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_enable = 0; idle(); get_num = '0; model_clear();
    for (int k = 0; k < RP; k++) set_port(k, 5);
    #12;
    tot_cnt++;
    if (dout(0) !== '0) $display("FAIL reset_out: got %h exp 0", dout(0)); else pass_cnt++;
    tot_cnt++;
    if (pending_count !== '0) $display("FAIL reset_count: got %0d exp 0", pending_count); else pass_cnt++;
    @(posedge clk); #1;
    reset_enable = 1;
    tick();
  endtask

  task automatic test_reset_async();
    idle(); set_num0 = 5; set_val0 = 32'hDEADBEEF; set_enable0 = 1; busy_enable = 1; busy_num = 6;
    set_port(0, 5); set_port(1, 6);
    tick(); idle();
    #1;
    tot_cnt++;
    if (dout(0) !== 32'hDEADBEEF || pending_count !== 1)
      $display("FAIL pre_reset: got %h/%0d exp deadbeef/1", dout(0), pending_count);
    else pass_cnt++;
    reset_enable = 0; #1;
    tot_cnt++;
    if (dout(0) !== '0 || pending_count !== 0 || busy[1] !== 1'b0)
      $display("FAIL async_reset: got %h/%0d/%b exp 0/0/0", dout(0), pending_count, busy[1]);
    else pass_cnt++;
    set_num0 = 6; set_val0 = 32'h1234; set_enable0 = 1; busy_enable = 1; busy_num = 7;
    tick(); tick();
    tot_cnt++;
    if (dout(1) !== '0 || pending_count !== 0)
      $display("FAIL reset_hold: got %h/%0d exp 0/0", dout(1), pending_count);
    else pass_cnt++;
    idle(); reset_enable = 1; tick();
    tot_cnt++;
    if (dout(0) !== '0 || dout(1) !== '0) $display("FAIL post_reset: got %h/%h exp 0/0", dout(0), dout(1));
    else pass_cnt++;
  endtask

  task automatic test_walk();
    for (int i = 1; i < D; i++) begin
      idle(); set_num0 = RI'(i); set_val0 = W'(i); set_enable0 = 1;
      for (int k = 0; k < RP; k++) set_port(k, (i + k) % D);
      tick(); idle(); #1;
      for (int k = 0; k < RP; k++) begin
        tot_cnt++;
        if (dout(k) !== exp_out(port_idx(k)))
          $display("FAIL walk r%0d port%0d: got %h exp %h", i, k, dout(k), exp_out(port_idx(k)));
        else pass_cnt++;
      end
      tot_cnt++;
      if (dout(0) !== W'(i)) $display("FAIL walk_val r%0d: got %h exp %h", i, dout(0), W'(i)); else pass_cnt++;
    end
    idle(); set_num1 = 0; set_val1 = '1; set_enable1 = 1; set_port(0, 0);
    tick(); idle(); #1;
    tot_cnt++;
    if (dout(0) !== '0) $display("FAIL r0_write: got %h exp 0", dout(0)); else pass_cnt++;
  endtask

  task automatic test_collision();
    idle(); set_num0 = 7; set_num1 = 7; set_val0 = 32'h11; set_val1 = 32'h22;
    set_enable0 = 1; set_enable1 = 1; set_port(0, 7);
    tick(); idle(); #1;
    tot_cnt++;
    if (dout(0) !== 32'h22) $display("FAIL collision: got %h exp 22", dout(0)); else pass_cnt++;
    idle(); set_num0 = 10; set_num1 = 11; set_val0 = 32'hA0; set_val1 = 32'hB1;
    set_enable0 = 1; set_enable1 = 1; set_port(0, 10); set_port(1, 11);
    tick(); idle(); #1;
    tot_cnt++;
    if (dout(0) !== 32'hA0 || dout(1) !== 32'hB1)
      $display("FAIL dual_write: got %h/%h exp a0/b1", dout(0), dout(1));
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    int exp_seq[3] = '{1, 2, 3};
    set_port(0, 4); set_port(1, 3); set_port(2, 5);
    for (int j = 0; j < 3; j++) begin
      idle(); busy_enable = 1; busy_num = RI'(3 + j);
      tick(); idle(); #1;
      tot_cnt++;
      if (pending_count !== exp_seq[j]) $display("FAIL mark_count %0d: got %0d exp %0d", j, pending_count, exp_seq[j]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (busy !== 3'b111) $display("FAIL busy_all: got %b exp 111", busy); else pass_cnt++;
    idle(); set_enable0 = 1; set_num0 = 4; set_val0 = 32'h44;
    tick(); idle(); #1;
    tot_cnt++;
    if (pending_count !== 2 || busy[0] !== 1'b0)
      $display("FAIL retire_r4: got %0d/%b exp 2/0", pending_count, busy[0]);
    else pass_cnt++;
    idle(); set_enable1 = 1; set_num1 = 3; set_val1 = 32'h33; busy_enable = 1; busy_num = 3;
    tick(); idle(); #1;
    tot_cnt++;
    if (pending_count !== 2 || busy[1] !== 1'b1 || dout(1) !== 32'h33)
      $display("FAIL remark_r3: got %0d/%b/%h exp 2/1/33", pending_count, busy[1], dout(1));
    else pass_cnt++;
    for (int i = 0; i < D; i++) begin
      idle(); busy_enable = 1; busy_num = RI'(i); tick();
    end
    idle(); #1;
    tot_cnt++;
    if (pending_count !== RI'(D - 1) || int'(pending_count) != m_count())
      $display("FAIL count_max: got %0d exp %0d", pending_count, D - 1);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    idle(); set_enable0 = 1; set_num0 = 9; set_val0 = 32'h55; set_port(0, 9); #1;
    tot_cnt++;
    if (dout(0) !== exp_out(9)) $display("FAIL bypass_pre: got %h exp %h", dout(0), exp_out(9)); else pass_cnt++;
    tick(); idle(); #1;
    tot_cnt++;
    if (dout(0) !== 32'h55) $display("FAIL bypass_post: got %h exp 55", dout(0)); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int k = 0; k < RP; k++) set_port(k, int'($urandom_range(0, 12)));
      set_enable0 = 1'($urandom); set_num0 = RI'($urandom_range(0, 12)); set_val0 = $urandom;
      set_enable1 = 1'($urandom); set_num1 = RI'($urandom_range(0, 12)); set_val1 = $urandom;
      busy_enable = 1'($urandom); busy_num = RI'($urandom_range(0, 12));
      #1;
      for (int k = 0; k < RP; k++) begin
        tot_cnt++;
        if (dout(k) !== exp_out(port_idx(k)) || busy[k] !== exp_busy(port_idx(k)))
          $display("FAIL rand %0d port%0d: got %h/%b exp %h/%b", n, k, dout(k), busy[k],
                   exp_out(port_idx(k)), exp_busy(port_idx(k)));
        else pass_cnt++;
      end
      tick();
      tot_cnt++;
      if (int'(pending_count) != m_count())
        $display("FAIL rand_count %0d: got %0d exp %0d", n, pending_count, m_count());
      else pass_cnt++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_reset_async();
    test_walk();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter WORD_SIZE, default 32, data word width in bits.
REQ-002 Parameter REG_INDEX, default 5, register index width; depth = 2**REG_INDEX.
REQ-003 Parameter READ_PORTS, default 3, number of independent read ports, range 1..8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_enable  input  1  reset, asynchronous, active-low.
REQ-006 get_num  input  READ_PORTS*REG_INDEX  read indices; port k at bits [k*REG_INDEX +: REG_INDEX].
REQ-007 out  output  READ_PORTS*WORD_SIZE  read data; port k at bits [k*WORD_SIZE +: WORD_SIZE].
REQ-008 busy  output  READ_PORTS  pending flag of the register addressed by read port k.
REQ-009 set_num0, set_val0, set_enable0  input  REG_INDEX, WORD_SIZE, 1  write port 0.
REQ-010 set_num1, set_val1, set_enable1  input  REG_INDEX, WORD_SIZE, 1  write port 1.
REQ-011 busy_num, busy_enable  input  REG_INDEX, 1  mark register as pending (producer issued).
REQ-012 pending_count  output  REG_INDEX+1  number of registers currently pending.

Function
REQ-013 Read: out[k] = stored value of register get_num[k], combinational, zero latency.
REQ-014 Register 0: reads 0 always; writes and busy marks to index 0 ignored; never pending.
REQ-015 Write: on rising edge with set_enableX=1, register set_numX <= set_valX.
REQ-016 Both write ports enabled, same index: port 1 value stored; port 0 discarded.
REQ-017 Both write ports enabled, different indices: both stored same edge.
REQ-018 Pending bit per register: set on edge when busy_enable=1 for busy_num; cleared on edge when either write port writes that register.
REQ-019 busy_enable and write to same register, same edge: pending stays/becomes 1 (new producer wins); data still written.
REQ-020 busy[k] = pending bit of register get_num[k], combinational.
REQ-021 pending_count: registered; after each edge equals popcount of pending bits as updated by that edge; max value 2**REG_INDEX-1, no wrap.
REQ-022 Pending bits and pending_count change only on clk edges or reset; no combinational path from write inputs to pending_count.

Reset
REQ-023 reset_enable=0: immediately, without clk, all registers = 0, all pending bits = 0, pending_count = 0.
REQ-024 Reset asserted mid-write or mid-mark: that edge's update lost; reset state holds while reset_enable=0.
REQ-025 First update after reset: first rising edge with reset_enable=1.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN defined: read port k whose get_num[k] matches an enabled write this cycle (nonzero index) returns that write's set_val (port 1 priority per REQ-016) and busy[k]=0 unless busy_enable targets same index; combinational.
REQ-027 REG_FILE_BYPASS_EN undefined: reads return stored value and stored pending bit only; written data visible after the edge.

Verification
REQ-028 Reset: reset_enable=0 for 2 cycles after writing 0xDEADBEEF to r5 -> out reads 0 at r5, pending_count=0, asynchronously before next edge.
REQ-029 Walk: write r1..r31 with value = index, READ_PORTS=3 reading r(i), r(i+1), r(i+2) -> each out equals index once written; r0 reads 0 after write of 0xFFFFFFFF.
REQ-030 Collision: set_num0=set_num1=7, set_val0=0x11, set_val1=0x22 -> r7=0x22 after edge.
REQ-031 Scoreboard: busy mark r3, r4, r5 on successive edges -> pending_count 1,2,3; write r4 -> 2, busy on port reading r4 drops; busy mark and write r3 same edge -> r3 stays pending, count 2.
REQ-032 Bypass: with REG_FILE_BYPASS_EN write r9=0x55 and read r9 same cycle -> out=0x55 before edge; without macro -> old value before edge, 0x55 after.
REQ-033 Width sweep: WORD_SIZE=16, REG_INDEX=3, READ_PORTS=1 -> REQ-029..031 pass; pending_count saturates at 7 with r1..r7 marked.
